alu_ctrl_pipe: RTL
==================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter M_EXT, default 1, meaning RV32M multiply/divide decode is enabled.
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning accept-to-out_valid cycles for MUL* (1..15).
REQ-003 SHALL have parameter DIV_LAT, default 32, meaning accept-to-out_valid cycles for DIV*/REM* (1..63).
REQ-004 SHALL have parameter OPW, default 5, meaning alu_op width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush  input  1  drops held or pending operation.
REQ-009 in_valid  input  1  opcode/funct3/funct7 valid.
REQ-010 in_ready  output  1  stage accepts this cycle.
REQ-011 opcode  input  7  instruction[6:0].
REQ-012 funct3  input  3  instruction[14:12].
REQ-013 funct7  input  7  instruction[31:25].
REQ-014 out_valid  output  1  alu_op/illegal valid.
REQ-015 out_ready  input  1  consumer takes output.
REQ-016 alu_op  output  OPW  registered ALU operation code.
REQ-017 illegal  output  1  registered illegal-encoding flag.
REQ-018 busy  output  1  multi-cycle M operation in progress.

Function
REQ-019 Accept SHALL occur when in_valid && in_ready; in_ready = (state==IDLE) || (state==HOLD && out_ready), forced 0 during rst or flush.
REQ-020 FSM SHALL have states IDLE, WAIT, HOLD; IDLE/HOLD --accept base op--> HOLD; --accept M op with LAT>1--> WAIT; WAIT --count==0--> HOLD; HOLD --out_ready, no accept--> IDLE.
REQ-021 Base ops SHALL present out_valid the cycle after accept (latency 1, throughput 1 op/cycle under continuous out_ready).
REQ-022 M ops SHALL present out_valid exactly LAT cycles after accept (MUL_LAT for funct3 0-3, DIV_LAT for 4-7); counter loads LAT-1, decrements in WAIT; busy=1 only in WAIT.
REQ-023 out_valid SHALL be 1 only in HOLD; alu_op/illegal SHALL remain stable in HOLD until out_ready.
REQ-024 OP (0110011): funct7 0000000 -> ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND by funct3; funct7 0100000 -> SUB (f3=000), SRA (f3=101); funct7 0000001 with M_EXT -> MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU; all else illegal.
REQ-025 OP-IMM (0010011): funct3 selects ADD,SLT,SLTU,XOR,OR,AND ignoring funct7; f3=001 requires funct7 0000000 (SLL); f3=101 funct7 0000000 -> SRL, 0100000 -> SRA; other funct7 on shifts illegal.
REQ-026 LOAD, STORE, JALR, JAL, AUIPC SHALL decode to ADD; BRANCH to SUB; LUI to PASS.
REQ-027 Any other opcode, or funct7 0000001 with M_EXT=0, SHALL give alu_op=NOP, illegal=1, latency 1.
REQ-028 flush SHALL force state IDLE, out_valid 0, busy 0, counter 0 next cycle; in-flight op discarded, no accept that cycle.
REQ-029 rst SHALL take priority over flush; flush over accept.

Reset
REQ-030 On rst: state IDLE, out_valid 0, busy 0, counter 0, alu_op NOP, illegal 0; in_ready 0 during rst, 1 the cycle after.
REQ-031 rst asserted in WAIT or HOLD SHALL abandon the operation with no out_valid pulse afterwards.

Structure
REQ-032 ALU op codes SHALL live in shared defines: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS 10, MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18, NOP 31; opcode constants likewise shared.
REQ-033 Combinational decode SHALL be sub-module alu_op_decode (opcode, funct3, funct7 -> op, illegal, is_mul, is_div); alu_ctrl_pipe holds FSM, counter, output register.

Verification
REQ-034 Back-to-back add,sub,sra (0110011/000/00, 000/20, 101/20), out_ready=1 -> alu_op 0,1,7 on consecutive cycles, in_ready held 1.
REQ-035 addi with funct7=0100000 (0010011/000/20) -> ADD, illegal 0; slli with funct7=0100000 -> NOP, illegal 1.
REQ-036 div (0110011/100/01), DIV_LAT=32 -> busy 31 cycles, out_valid exactly cycle 32 after accept, alu_op 15, in_ready 0 meanwhile.
REQ-037 out_ready=0 for 5 cycles after jal (1101111) -> alu_op 0 stable, in_ready 0; release with in_valid=1 -> new op accepted same cycle.
REQ-038 flush at cycle 10 of div -> out_valid never asserts for it, busy 0 next cycle; rst in HOLD -> out_valid 0, alu_op 31 next cycle.
REQ-039 M_EXT=0, mul (0110011/000/01) -> NOP, illegal 1, latency 1.

Source files
------------

// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared constants for the ALU control stage: ALU op codes, RV32 major opcodes,
// funct7 classes, FSM state type and the funct3 map for plain register ops.
package alu_ctrl_pipe_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASS   = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;
  localparam logic [4:0] ALU_NOP    = 5'd31;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// Instruction-in / ALU-op-out bus of the ALU control stage.
// Handshake: a transfer happens on a rising edge where valid && ready; valid must
// not depend on ready, and the payload is held stable while valid && !ready.
interface alu_ctrl_pipe_if #(
  parameter int OPW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] alu_op;
  logic           illegal;

  modport master (
    output in_valid, opcode, funct3, funct7, out_ready,
    input  in_ready, out_valid, alu_op, illegal
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, out_ready,
    output in_ready, out_valid, alu_op, illegal
  );
endinterface

// File: rtl/alu_ctrl_pipe_decode.sv
// Combinational RV32I(+M) decode of opcode/funct3/funct7 into an ALU op code,
// an illegal flag and multiply/divide class bits.
module alu_op_decode
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [4:0] op,
  output logic       illegal,
  output logic       is_mul,
  output logic       is_div
);

  always_comb begin
    op      = ALU_NOP;
    illegal = 1'b1;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          op      = base_op(funct3);
          illegal = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op      = ALU_SUB;
          illegal = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op      = ALU_SRA;
          illegal = 1'b0;
        end else if (funct7 == F7_MULDIV && M_EXT != 0) begin
          // MUL..REMU are numbered consecutively in funct3 order
          op      = ALU_MUL + {2'b00, funct3};
          illegal = 1'b0;
          is_mul  = !funct3[2];
          is_div  = funct3[2];
        end
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) begin
              op      = ALU_SLL;
              illegal = 1'b0;
            end
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              op      = ALU_SRL;
              illegal = 1'b0;
            end else if (funct7 == F7_ALT) begin
              op      = ALU_SRA;
              illegal = 1'b0;
            end
          end
          default: begin
            op      = base_op(funct3);
            illegal = 1'b0;
          end
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_JAL, OPC_AUIPC: begin
        op      = ALU_ADD;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        op      = ALU_SUB;
        illegal = 1'b0;
      end
      OPC_LUI: begin
        op      = ALU_PASS;
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ALU control pipeline stage: registers the decoded ALU op, holds it until taken,
// and stretches multiply/divide ops to their configured latency.
module alu_ctrl_pipe
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32,
  parameter int OPW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alu_ctrl_pipe_if.slave    bus,
  output logic              busy,
  output state_e            o_dbg_state
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;
  logic [4:0] r_op;
  logic       r_ill;
  logic [4:0] w_dec_op;
  logic       w_dec_ill;
  logic       w_is_mul;
  logic       w_is_div;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_multi;

  alu_op_decode #(.M_EXT(M_EXT)) u_decode (
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .op      (w_dec_op),
    .illegal (w_dec_ill),
    .is_mul  (w_is_mul),
    .is_div  (w_is_div)
  );

  assign w_in_ready = !rst && !flush &&
                      (r_state == ST_IDLE || (r_state == ST_HOLD && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_multi    = (w_is_mul && MUL_LAT > 1) || (w_is_div && DIV_LAT > 1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_WAIT: begin
        // the counter reaches zero on the same edge that enters HOLD
        w_cnt_nxt = r_cnt - 6'd1;
        if (r_cnt <= 6'd1) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready && !w_accept) w_state_nxt = ST_IDLE;
      end
      default: ;
    endcase
    if (w_accept) begin
      if (w_multi) begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = w_is_mul ? MUL_CNT : DIV_CNT;
      end else begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = 6'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
      r_op    <= ALU_NOP;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op  <= w_dec_op;
        r_ill <= w_dec_ill;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.alu_op    = OPW'(r_op);
  assign bus.illegal   = r_ill;
  assign busy          = (r_state == ST_WAIT);
  assign o_dbg_state   = r_state;

endmodule
